online_ca_bank: RTL and testbench
=================================

Name: online_ca_bank

Overview:
- Multi-channel on-the-fly CA (conversion/append) history buffer for the online divider datapath.
- Each channel collects a serial signed-digit stream (plus/minus bit pair per digit) into a word-wide shift vector. It exposes the MSB-aligned live word, commits aligned words into an internal memory, and reads committed words back through a configurable pipeline.
- Successor to the two-operand CA register: it adds a parametrised channel count, an internal validity-tracked store, read-during-write forwarding, and overflow/illegal-digit detection.

Parameters:
- UNROLLING, 64, digits per word (vector width per channel).
- CHANNELS, 2, number of independent digit streams.
- ADDR_WIDTH, 7, store address width; depth = 2**ADDR_WIDTH.
- READ_DELAY, 1, extra register stages after the store read (0..4).

Ports:
- clk  in  1  single clock, rising edge.
- syn_reset  in  1  synchronous active-high reset.
- enable  in  1  global advance. When 0, all state and pipelines hold (syn_reset still acts).
- refresh  in  1  start a new word.
- digit_valid  in  1  digit_in is valid this cycle.
- digit_in  in  2*CHANNELS  channel c digit = {plus,minus} at bits [2c+1:2c].
- commit  in  1  write the current aligned word of every channel to wr_addr.
- wr_addr  in  ADDR_WIDTH  store write address.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  store read address.
- cur_plus, cur_minus  out  CHANNELS*UNROLLING  live MSB-aligned words, channel c at [c*UNROLLING +: UNROLLING].
- rd_plus, rd_minus  out  CHANNELS*UNROLLING  read data.
- rd_valid  out  1  rd_plus/rd_minus hold the response to a read.
- digit_cnt  out  clog2(UNROLLING+1)  digits in the current word.
- overflow  out  1  sticky: a digit arrived while digit_cnt==UNROLLING.
- bad_digit  out  1  sticky: an illegal digit 2'b11 was received.

Behaviour:
- syn_reset (priority over everything): all shift vectors 0, digit_cnt 0, overflow 0, bad_digit 0, all entry-valid bits 0, read pipeline cleared, rd_valid 0, rd_plus/rd_minus 0. Reset mid-word or mid-read discards all in-flight data.
- All updates below occur only on edges where enable=1.
- Digit capture:
  - refresh=1: vectors cleared. If digit_valid, the digit is placed at bit 0 and digit_cnt becomes 1; otherwise digit_cnt becomes 0. overflow and bad_digit are cleared.
  - refresh=0, digit_valid=1, digit_cnt<UNROLLING: each vector shifts left one place, the new bit enters at bit 0, digit_cnt increments.
  - refresh=0, digit_valid=1, digit_cnt==UNROLLING: digit dropped, vectors unchanged, overflow set.
- Illegal digit: a 2'b11 on any channel is stored as 2'b00 for that channel and still counted; bad_digit is set. If refresh=1 in the same cycle, bad_digit is set (set wins over clear).
- Alignment (combinational from registers): cur = vec << (UNROLLING - digit_cnt). The first digit sits at the MSB, with zeros below the last digit. cur = 0 when digit_cnt==0.
- Commit:
  - mem[wr_addr] <= cur_* as registered before the edge, so the digit arriving this cycle is excluded. The entry-valid bit for wr_addr is set.
  - commit+refresh in the same cycle closes the old word and starts the new one.
- Read:
  - rd_en samples rd_addr; the store produces data at the next edge; READ_DELAY further stages follow.
  - Response on rd_plus/rd_minus, with rd_valid=1, exactly 1+READ_DELAY enabled cycles after the request. Back-to-back requests are accepted every cycle.
  - rd_valid=0 on cycles with no response. On those cycles rd_plus/rd_minus hold their last value.
  - An entry whose valid bit is 0 reads as all zeros.
  - Read-during-write to the same address in the same cycle returns the newly written word (forwarding).
- enable=0 freezes digit_cnt, vectors, store, flags, pipeline contents, rd_valid and read data; latency is counted in enabled cycles only.

Test Plan:
- Reset, then read addr 5 with READ_DELAY=1 -> rd_valid high 2 cycles later, rd_plus=rd_minus=0; digit_cnt=0, flags 0.
- refresh with digit 10, then digits 01,10 (ch0), UNROLLING=64 -> digit_cnt=3; cur_plus[63:61]=101, cur_minus[63:61]=010, lower bits 0.
- Three digits as above, then commit with wr_addr=3 and refresh in the same cycle, then read addr 3 -> response holds the 3-digit aligned word; digit_cnt restarts at 0/1.
- Feed 65 valid digits after refresh -> digit_cnt=64, overflow=1 after the 65th, vector unchanged; next refresh clears overflow.
- digit_in ch1=2'b11 -> bad_digit=1, ch1 digit stored as 0, digit_cnt still increments.
- Commit to addr 9 while rd_en with rd_addr=9 in the same cycle -> read returns the new word. Toggle enable=0 for 3 cycles mid-read -> response latency is extended by exactly 3 cycles and data is unchanged.

Source files
------------

// File: rtl/online_ca_bank.sv
// online_ca_bank: multi-channel on-the-fly conversion/append history buffer.
// Each channel shifts a serial signed-digit stream (plus/minus bit pair) into
// a word-wide vector, exposes it MSB-aligned, commits aligned words into a
// validity-tracked store and reads them back through a READ_DELAY pipeline.
module online_ca_bank #(
    parameter int UNROLLING  = 64,
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 7,
    parameter int READ_DELAY = 1
) (
    input  logic                              clk,
    input  logic                              syn_reset,
    input  logic                              enable,
    input  logic                              refresh,
    input  logic                              digit_valid,
    input  logic [2*CHANNELS-1:0]             digit_in,
    input  logic                              commit,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic                              rd_en,
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic [CHANNELS*UNROLLING-1:0]     cur_plus,
    output logic [CHANNELS*UNROLLING-1:0]     cur_minus,
    output logic [CHANNELS*UNROLLING-1:0]     rd_plus,
    output logic [CHANNELS*UNROLLING-1:0]     rd_minus,
    output logic                              rd_valid,
    output logic [$clog2(UNROLLING+1)-1:0]    digit_cnt,
    output logic                              overflow,
    output logic                              bad_digit
);

    localparam int CNT_W = $clog2(UNROLLING + 1);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int WW    = CHANNELS * UNROLLING;
    localparam logic [CNT_W-1:0] UNR_C = CNT_W'(UNROLLING);

    // The illegal code 2'b11 is neutralised to a zero digit.
    function automatic logic [1:0] sanitize_digit(input logic [1:0] d);
        logic [1:0] r;
        case (d)
            2'b11:   r = 2'b00;
            default: r = d;
        endcase
        return r;
    endfunction

    logic [WW-1:0]      vec_plus_r, vec_minus_r, vec_plus_s, vec_minus_s;
    logic [CNT_W-1:0]   digit_cnt_r, digit_cnt_s, shamt_s;
    logic               ovf_r, ovf_s, bad_r, bad_s;
    logic [CHANNELS-1:0] dig_p_s, dig_m_s;
    logic               any_bad_s;

    logic [WW-1:0]      mem_plus_r  [0:DEPTH-1];
    logic [WW-1:0]      mem_minus_r [0:DEPTH-1];
    logic [DEPTH-1:0]   entry_vld_r;
    logic [WW-1:0]      rd_data_p_s, rd_data_m_s;

    logic               stg_in_v_s [0:READ_DELAY];
    logic [WW-1:0]      stg_in_p_s [0:READ_DELAY];
    logic [WW-1:0]      stg_in_m_s [0:READ_DELAY];
    logic               pipe_v_r   [0:READ_DELAY];
    logic [WW-1:0]      pipe_p_r   [0:READ_DELAY];
    logic [WW-1:0]      pipe_m_r   [0:READ_DELAY];

    // Split the incoming digit bus per channel and flag illegal codes.
    always_comb begin
        any_bad_s = 1'b0;
        dig_p_s   = {CHANNELS{1'b0}};
        dig_m_s   = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            {dig_p_s[c], dig_m_s[c]} = sanitize_digit(digit_in[2*c +: 2]);
            any_bad_s = any_bad_s | (digit_in[2*c +: 2] == 2'b11);
        end
    end

    // Next-state of shift vectors, digit counter and sticky flags.
    always_comb begin
        vec_plus_s  = vec_plus_r;
        vec_minus_s = vec_minus_r;
        digit_cnt_s = digit_cnt_r;
        ovf_s       = ovf_r;
        bad_s       = bad_r;
        if (refresh) begin
            vec_plus_s  = {WW{1'b0}};
            vec_minus_s = {WW{1'b0}};
            ovf_s       = 1'b0;
            if (digit_valid) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    vec_plus_s[c*UNROLLING]  = dig_p_s[c];
                    vec_minus_s[c*UNROLLING] = dig_m_s[c];
                end
                digit_cnt_s = CNT_W'(1);
                bad_s       = any_bad_s;
            end else begin
                digit_cnt_s = {CNT_W{1'b0}};
                bad_s       = 1'b0;
            end
        end else if (digit_valid) begin
            bad_s = bad_r | any_bad_s;
            if (digit_cnt_r < UNR_C) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    vec_plus_s[c*UNROLLING +: UNROLLING] =
                        {vec_plus_r[c*UNROLLING +: UNROLLING-1], dig_p_s[c]};
                    vec_minus_s[c*UNROLLING +: UNROLLING] =
                        {vec_minus_r[c*UNROLLING +: UNROLLING-1], dig_m_s[c]};
                end
                digit_cnt_s = digit_cnt_r + CNT_W'(1);
            end else begin
                ovf_s = 1'b1;
            end
        end else begin
            digit_cnt_s = digit_cnt_r;
        end
    end

    // Digit-capture state register.
    always_ff @(posedge clk) begin
        if (syn_reset) begin
            vec_plus_r  <= {WW{1'b0}};
            vec_minus_r <= {WW{1'b0}};
            digit_cnt_r <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            bad_r       <= 1'b0;
        end else if (enable) begin
            vec_plus_r  <= vec_plus_s;
            vec_minus_r <= vec_minus_s;
            digit_cnt_r <= digit_cnt_s;
            ovf_r       <= ovf_s;
            bad_r       <= bad_s;
        end
    end

    // MSB alignment: first digit lands at the top, zeros fill below.
    always_comb begin
        shamt_s   = UNR_C - digit_cnt_r;
        cur_plus  = {WW{1'b0}};
        cur_minus = {WW{1'b0}};
        if (digit_cnt_r != {CNT_W{1'b0}}) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cur_plus[c*UNROLLING +: UNROLLING]  = vec_plus_r[c*UNROLLING +: UNROLLING]  << shamt_s;
                cur_minus[c*UNROLLING +: UNROLLING] = vec_minus_r[c*UNROLLING +: UNROLLING] << shamt_s;
            end
        end else begin
            cur_plus  = {WW{1'b0}};
            cur_minus = {WW{1'b0}};
        end
    end

    // Store data array; contents are qualified by entry_vld_r, so no reset.
    always_ff @(posedge clk) begin
        if (!syn_reset && enable && commit) begin
            mem_plus_r[wr_addr]  <= cur_plus;
            mem_minus_r[wr_addr] <= cur_minus;
        end
    end

    // Per-entry valid bits.
    always_ff @(posedge clk) begin
        if (syn_reset) begin
            entry_vld_r <= {DEPTH{1'b0}};
        end else if (enable && commit) begin
            entry_vld_r[wr_addr] <= 1'b1;
        end
    end

    // Store read with same-cycle write forwarding and invalid-entry zeroing.
    always_comb begin
        if (commit && (wr_addr == rd_addr)) begin
            rd_data_p_s = cur_plus;
            rd_data_m_s = cur_minus;
        end else if (entry_vld_r[rd_addr]) begin
            rd_data_p_s = mem_plus_r[rd_addr];
            rd_data_m_s = mem_minus_r[rd_addr];
        end else begin
            rd_data_p_s = {WW{1'b0}};
            rd_data_m_s = {WW{1'b0}};
        end
    end

    // Inputs of each read pipeline stage.
    always_comb begin
        stg_in_v_s[0] = rd_en;
        stg_in_p_s[0] = rd_data_p_s;
        stg_in_m_s[0] = rd_data_m_s;
        for (int i = 1; i <= READ_DELAY; i++) begin
            stg_in_v_s[i] = pipe_v_r[i-1];
            stg_in_p_s[i] = pipe_p_r[i-1];
            stg_in_m_s[i] = pipe_m_r[i-1];
        end
    end

    // Read pipeline; the last stage only loads on a response so data holds.
    always_ff @(posedge clk) begin
        if (syn_reset) begin
            for (int i = 0; i <= READ_DELAY; i++) begin
                pipe_v_r[i] <= 1'b0;
                pipe_p_r[i] <= {WW{1'b0}};
                pipe_m_r[i] <= {WW{1'b0}};
            end
        end else if (enable) begin
            for (int i = 0; i <= READ_DELAY; i++) begin
                pipe_v_r[i] <= stg_in_v_s[i];
                if ((i < READ_DELAY) || stg_in_v_s[i]) begin
                    pipe_p_r[i] <= stg_in_p_s[i];
                    pipe_m_r[i] <= stg_in_m_s[i];
                end
            end
        end
    end

    assign rd_valid  = pipe_v_r[READ_DELAY];
    assign rd_plus   = pipe_p_r[READ_DELAY];
    assign rd_minus  = pipe_m_r[READ_DELAY];
    assign digit_cnt = digit_cnt_r;
    assign overflow  = ovf_r;
    assign bad_digit = bad_r;

endmodule

// File: tb/tb_online_ca_bank.sv
// Self-checking bench for online_ca_bank: reference model plus read scoreboard.
module tb_online_ca_bank;

    localparam int U  = 64;
    localparam int CH = 2;
    localparam int AW = 7;
    localparam int RD = 1;
    localparam int WW = CH * U;

    logic            clk;
    logic            syn_reset, enable, refresh, digit_valid, commit, rd_en;
    logic [2*CH-1:0] digit_in;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic [WW-1:0]   cur_plus, cur_minus, rd_plus, rd_minus;
    logic            rd_valid, overflow, bad_digit;
    logic [6:0]      digit_cnt;

    online_ca_bank #(.UNROLLING(U), .CHANNELS(CH), .ADDR_WIDTH(AW), .READ_DELAY(RD)) dut (
        .clk(clk), .syn_reset(syn_reset), .enable(enable), .refresh(refresh),
        .digit_valid(digit_valid), .digit_in(digit_in), .commit(commit),
        .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .cur_plus(cur_plus), .cur_minus(cur_minus), .rd_plus(rd_plus),
        .rd_minus(rd_minus), .rd_valid(rd_valid), .digit_cnt(digit_cnt),
        .overflow(overflow), .bad_digit(bad_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WW-1:0] m_cur_p, m_cur_m;
    int            m_cnt;
    bit            m_ovf, m_bad;
    logic [WW-1:0] m_mem_p [0:127];
    logic [WW-1:0] m_mem_m [0:127];
    bit            m_vld   [0:127];

    // Read scoreboard
    logic [WW-1:0] q_p [$];
    logic [WW-1:0] q_m [$];
    int            q_t [$];
    int            en_cnt = 0;
    logic [WW-1:0] last_p = '0, last_m = '0;

    task automatic check_val(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Monitor: pops one expected response per enabled edge with rd_valid.
    always begin
        bit en_q, rst_q;
        @(posedge clk);
        en_q  = enable;
        rst_q = syn_reset;
        if (en_q && !rst_q) en_cnt++;
        #1;
        if (rst_q) begin
            last_p = '0;
            last_m = '0;
        end else if (en_q) begin
            if (rd_valid) begin
                if (q_p.size() == 0) begin
                    check_val("rd_spurious", {{(WW-1){1'b0}}, rd_valid}, '0);
                end else begin
                    logic [WW-1:0] ep, em;
                    int et;
                    ep = q_p.pop_front();
                    em = q_m.pop_front();
                    et = q_t.pop_front();
                    check_val("rd_plus", rd_plus, ep);
                    check_val("rd_minus", rd_minus, em);
                    check_val("rd_latency", WW'(en_cnt), WW'(et));
                    last_p = ep;
                    last_m = em;
                end
            end else begin
                check_val("rd_hold_p", rd_plus, last_p);
                check_val("rd_hold_m", rd_minus, last_m);
            end
        end
    end

    task automatic model_clear();
        m_cur_p = '0; m_cur_m = '0; m_cnt = 0; m_ovf = 0; m_bad = 0;
        for (int a = 0; a < 128; a++) m_vld[a] = 0;
    endtask

    task automatic do_reset();
        syn_reset = 1'b1; enable = 1'b1; refresh = 1'b0; digit_valid = 1'b0;
        digit_in = '0; commit = 1'b0; wr_addr = '0; rd_en = 1'b0; rd_addr = '0;
        model_clear();
        q_p.delete(); q_m.delete(); q_t.delete();
        @(posedge clk); #1;
        syn_reset = 1'b0;
        check_val("rst_cnt", WW'(digit_cnt), '0);
        check_val("rst_ovf", WW'(overflow), '0);
        check_val("rst_bad", WW'(bad_digit), '0);
        check_val("rst_rdv", WW'(rd_valid), '0);
        check_val("rst_rdp", rd_plus, '0);
        check_val("rst_rdm", rd_minus, '0);
        check_val("rst_curp", cur_plus, '0);
    endtask

    // One clock cycle of stimulus with model update and live-state checks.
    task automatic drive(input bit en, input bit rf, input bit dv, input logic [3:0] dig,
                         input bit cm, input logic [6:0] wa, input bit re, input logic [6:0] ra);
        enable = en; refresh = rf; digit_valid = dv; digit_in = dig;
        commit = cm; wr_addr = wa; rd_en = re; rd_addr = ra;
        if (en) begin
            if (re) begin
                if (cm && (wa == ra)) begin
                    q_p.push_back(m_cur_p); q_m.push_back(m_cur_m);
                end else if (m_vld[ra]) begin
                    q_p.push_back(m_mem_p[ra]); q_m.push_back(m_mem_m[ra]);
                end else begin
                    q_p.push_back('0); q_m.push_back('0);
                end
                q_t.push_back(en_cnt + 1 + RD);
            end
            if (cm) begin
                m_mem_p[wa] = m_cur_p; m_mem_m[wa] = m_cur_m; m_vld[wa] = 1;
            end
            if (rf) begin
                m_cur_p = '0; m_cur_m = '0; m_cnt = 0; m_ovf = 0; m_bad = 0;
            end
            if (dv) begin
                for (int c = 0; c < CH; c++)
                    if (dig[2*c +: 2] == 2'b11) m_bad = 1;
                if (m_cnt < U) begin
                    for (int c = 0; c < CH; c++) begin
                        logic [1:0] d;
                        d = dig[2*c +: 2];
                        if (d == 2'b11) d = 2'b00;
                        m_cur_p[c*U + U - 1 - m_cnt] = d[1];
                        m_cur_m[c*U + U - 1 - m_cnt] = d[0];
                    end
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(posedge clk); #1;
        check_val("digit_cnt", WW'(digit_cnt), WW'(m_cnt));
        check_val("overflow", WW'(overflow), WW'(m_ovf));
        check_val("bad_digit", WW'(bad_digit), WW'(m_bad));
        check_val("cur_plus", cur_plus, m_cur_p);
        check_val("cur_minus", cur_minus, m_cur_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 4'b0000, 0, 7'd0, 0, 7'd0);
    endtask

    initial begin
        syn_reset = 1'b1;
        do_reset();

        // Read of an unwritten entry after reset.
        drive(1, 0, 0, 4'b0000, 0, 7'd0, 1, 7'd5);
        idle(3);

        // Three-digit word: ch0 = 10,01,10 and ch1 = 01,10,01.
        drive(1, 1, 1, 4'b0110, 0, 7'd0, 0, 7'd0);
        drive(1, 0, 1, 4'b1001, 0, 7'd0, 0, 7'd0);
        drive(1, 0, 1, 4'b0110, 0, 7'd0, 0, 7'd0);
        begin
            logic [WW-1:0] tp, tm;
            tp = cur_plus; tm = cur_minus;
            check_val("tp_cnt3", WW'(digit_cnt), WW'(3));
            check_val("tp_ch0_p", WW'(tp[63:61]), WW'(3'b101));
            check_val("tp_ch0_m", WW'(tm[63:61]), WW'(3'b010));
            check_val("tp_ch0_lo", WW'(tp[60:0] | tm[60:0]), '0);
        end

        // Commit + refresh closes the old word and starts a new one.
        drive(1, 1, 1, 4'b0001, 1, 7'd3, 0, 7'd0);
        drive(1, 0, 0, 4'b0000, 0, 7'd0, 1, 7'd3);
        idle(3);

        // 65 digits after refresh: the last one overflows and is dropped.
        drive(1, 1, 0, 4'b0000, 0, 7'd0, 0, 7'd0);
        for (int k = 0; k < 65; k++) begin
            logic [1:0] a, b;
            a = 2'($urandom_range(0, 2));
            b = 2'($urandom_range(0, 2));
            drive(1, 0, 1, {b, a}, 0, 7'd0, 0, 7'd0);
        end
        check_val("ovf_cnt64", WW'(digit_cnt), WW'(64));
        check_val("ovf_set", WW'(overflow), WW'(1));
        drive(1, 0, 0, 4'b0000, 1, 7'd20, 0, 7'd0);
        drive(1, 1, 0, 4'b0000, 0, 7'd0, 1, 7'd20);
        check_val("ovf_clr", WW'(overflow), '0);

        // Illegal digit on ch1 is stored as zero but counted.
        drive(1, 0, 1, 4'b1101, 0, 7'd0, 0, 7'd0);
        check_val("bad_set", WW'(bad_digit), WW'(1));
        drive(1, 0, 1, 4'b1010, 0, 7'd0, 0, 7'd0);
        drive(1, 1, 1, 4'b1100, 0, 7'd0, 0, 7'd0);
        check_val("bad_set_wins", WW'(bad_digit), WW'(1));
        drive(1, 0, 1, 4'b0110, 0, 7'd0, 0, 7'd0);

        // Read-during-write to 9, then a 3-cycle enable stall mid-read.
        drive(1, 0, 1, 4'b1001, 1, 7'd9, 1, 7'd9);
        drive(0, 0, 1, 4'b0101, 1, 7'd4, 1, 7'd4);
        drive(0, 1, 0, 4'b0000, 0, 7'd0, 1, 7'd9);
        drive(0, 0, 1, 4'b1111, 0, 7'd0, 0, 7'd0);
        idle(3);

        // Back-to-back reads, including an entry never written.
        drive(1, 0, 0, 4'b0000, 0, 7'd0, 1, 7'd3);
        drive(1, 0, 0, 4'b0000, 0, 7'd0, 1, 7'd9);
        drive(1, 0, 0, 4'b0000, 0, 7'd0, 1, 7'd100);
        drive(1, 0, 0, 4'b0000, 0, 7'd0, 1, 7'd20);
        idle(3);

        // Reset while a read is in flight discards it and the store.
        drive(1, 0, 0, 4'b0000, 0, 7'd0, 1, 7'd9);
        do_reset();
        drive(1, 0, 0, 4'b0000, 0, 7'd0, 1, 7'd9);
        idle(3);

        check_val("rd_pending", WW'(q_p.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1);
    end

endmodule
